sp_sram_arbiter: RTL

Two-requester arbiter and sequencer for one single-port SRAM (CLK, CSN, ADDR, WEN, BE, DI, DOUT; synchronous write, asynchronous read).
- Port A: read-only instruction fetch. Port B: read/write data access.
- Accepts at most one request per cycle, drives the SRAM from registered command signals, and returns read data through a registered response.
- Sits between the core's fetch/LSU and the unified memory.

---
 rtl/sp_sram_arb_pkg.sv | 19 +
 rtl/sp_sram_grant.sv | 71 +++++++
 rtl/sp_sram_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sp_sram_arb_pkg.sv
// Shared definitions for the single-port SRAM arbiter.
//   cmd_state_e : state of the registered SRAM command
//   ARB_RR      : round-robin arbitration
//   ARB_PRIO    : fixed priority to port B with a starvation guard on port A
//   CNT_W       : width of the starvation counter
package sp_sram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmdA,
    StCmdBRd,
    StCmdBWr
  } cmd_state_e;

  localparam int unsigned ARB_RR   = 0;
  localparam int unsigned ARB_PRIO = 1;
  localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/sp_sram_grant.sv
// Grant logic for the two SRAM requesters.
// Grants are combinational from the requests and the arbiter state; a grant always
// means a transfer on the next rising edge, so the state advances on grants.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   a_req, b_req   : requests from port A (fetch) and port B (data)
//   a_gnt, b_gnt   : one-hot grants, never high without the matching request
module sp_sram_grant
  import sp_sram_arb_pkg::*;
#(
  parameter int unsigned ARB_MODE     = ARB_RR,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  localparam logic [CNT_W-1:0] StarveCnt = CNT_W'(STARVE_LIMIT);

  // rr_ptr_q = 0: A wins the next conflict, 1: B wins it.
  logic             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (ARB_MODE == ARB_PRIO) begin
      if (a_req && (!b_req || (starve_q == StarveCnt))) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end else begin
      if (a_req && (!b_req || !rr_ptr_q)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    starve_d = starve_q;
    if (a_gnt) begin
      rr_ptr_d = 1'b1;
      starve_d = '0;
    end else if (b_gnt) begin
      rr_ptr_d = 1'b0;
      // Only B grants that make A wait count towards forcing A.
      if (a_req && (starve_q != '1)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
      starve_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/sp_sram_arbiter.sv
// Two-requester arbiter and sequencer for one single-port SRAM with synchronous
// write and asynchronous read. Port A is read-only fetch, port B reads and writes.
// A transfer at edge k drives the SRAM from registers during k..k+1; read data is
// captured at edge k+1 and presented with a one-cycle RVALID.
// Ports:
//   CLK, RSTn                         : clock, asynchronous active-low reset
//   A_REQ, A_ADDR, A_GNT              : port A request / address / grant
//   A_RVALID, A_RDATA                 : port A read response
//   B_REQ, B_WE, B_BE, B_ADDR, B_WDATA: port B request and command fields
//   B_GNT, B_RVALID, B_RDATA          : port B grant and read response
//   CSN, WEN, BE, ADDR, DI            : registered SRAM command
//   DOUT                              : SRAM read data
module sp_sram_arbiter
  import sp_sram_arb_pkg::*;
#(
  parameter int unsigned AWIDTH       = 12,
  parameter int unsigned ARB_MODE     = ARB_RR,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              A_REQ,
  input  logic [AWIDTH-1:0] A_ADDR,
  output logic              A_GNT,
  output logic              A_RVALID,
  output logic [31:0]       A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [3:0]        B_BE,
  input  logic [AWIDTH-1:0] B_ADDR,
  input  logic [31:0]       B_WDATA,
  output logic              B_GNT,
  output logic              B_RVALID,
  output logic [31:0]       B_RDATA,
  output logic              CSN,
  output logic              WEN,
  output logic [3:0]        BE,
  output logic [AWIDTH-1:0] ADDR,
  output logic [31:0]       DI,
  input  logic [31:0]       DOUT
);

  logic a_gnt, b_gnt;

  sp_sram_grant #(
    .ARB_MODE     (ARB_MODE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk   (CLK),
    .rst_n (RSTn),
    .a_req (A_REQ),
    .b_req (B_REQ),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  assign A_GNT = a_gnt;
  assign B_GNT = b_gnt;

  cmd_state_e        state_q, state_d;
  logic              csn_q, csn_d;
  logic              wen_q, wen_d;
  logic [3:0]        be_q, be_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       di_q, di_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic [31:0]       a_rdata_q, b_rdata_q;

  // Next command: a grant now is a transfer at the coming edge.
  always_comb begin
    state_d = StIdle;
    if (a_gnt) begin
      state_d = StCmdA;
    end else if (b_gnt) begin
      state_d = B_WE ? StCmdBWr : StCmdBRd;
    end
  end

  always_comb begin
    csn_d  = 1'b1;
    wen_d  = 1'b1;
    be_d   = '0;
    addr_d = addr_q;
    di_d   = di_q;
    unique case (state_d)
      StIdle: ;
      StCmdA: begin
        csn_d  = 1'b0;
        addr_d = A_ADDR;
      end
      StCmdBRd: begin
        csn_d  = 1'b0;
        addr_d = B_ADDR;
      end
      StCmdBWr: begin
        csn_d  = 1'b0;
        wen_d  = 1'b0;
        be_d   = B_BE;
        addr_d = B_ADDR;
        di_d   = B_WDATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
      csn_q   <= 1'b1;
      wen_q   <= 1'b1;
      be_q    <= '0;
      addr_q  <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      csn_q   <= csn_d;
      wen_q   <= wen_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
    end
  end

  // Asynchronous-read SRAM: DOUT is valid for the command in flight, so capture it
  // at the edge that ends the command.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= (state_q == StCmdA);
      b_rvalid_q <= (state_q == StCmdBRd);
      if (state_q == StCmdA) begin
        a_rdata_q <= DOUT;
      end
      if (state_q == StCmdBRd) begin
        b_rdata_q <= DOUT;
      end
    end
  end

  assign CSN      = csn_q;
  assign WEN      = wen_q;
  assign BE       = be_q;
  assign ADDR     = addr_q;
  assign DI       = di_q;
  assign A_RVALID = a_rvalid_q;
  assign A_RDATA  = a_rdata_q;
  assign B_RVALID = b_rvalid_q;
  assign B_RDATA  = b_rdata_q;

endmodule
